// File: rtl/bg_affine_pkg.sv
// Shared types and helpers for the affine BG coordinate generator.
// Map-size encoding, pixel-size lookup, default widths, sign-extend.
package bg_affine_pkg;

  localparam int DEF_REF_W   = 28;
  localparam int DEF_FRAC    = 8;
  localparam int DEF_PARAM_W = 16;
  localparam int DEF_COORD_W = 10;

  typedef enum logic [1:0] {
    MAP_128  = 2'd0,
    MAP_256  = 2'd1,
    MAP_512  = 2'd2,
    MAP_1024 = 2'd3
  } map_size_e;

  function automatic int unsigned map_px(
    input map_size_e ms
  );
    return 32'd128 << ms;
  endfunction

  function automatic logic [DEF_REF_W-1:0] sext(
    input logic [DEF_PARAM_W-1:0] p
  );
    return {{(DEF_REF_W-DEF_PARAM_W){p[DEF_PARAM_W-1]}}, p};
  endfunction

endpackage

// File: rtl/bg_affine_chan.sv
// One affine channel: line/current accumulators plus pending reload.
// In: refs, params, control pulses. Out: current X/Y accumulators.
module bg_affine_chan #(
  parameter int REF_W   = 28,
  parameter int PARAM_W = 16
) (
  input  logic               clock,
  input  logic               rst_b,
  input  logic [REF_W-1:0]   bgx,
  input  logic [REF_W-1:0]   bgy,
  input  logic [PARAM_W-1:0] pa,
  input  logic [PARAM_W-1:0] pb,
  input  logic [PARAM_W-1:0] pc,
  input  logic [PARAM_W-1:0] pd,
  input  logic               ref_wr,
  input  logic               newframe,
  input  logic               steprow,
  input  logic               step,
  output logic [REF_W-1:0]   cur_x,
  output logic [REF_W-1:0]   cur_y
);

  logic [REF_W-1:0] lx_q, lx_d;
  logic [REF_W-1:0] ly_q, ly_d;
  logic [REF_W-1:0] cx_q, cx_d;
  logic [REF_W-1:0] cy_q, cy_d;
  logic             pend_q, pend_d;

  logic [REF_W-1:0] pa_x, pb_x, pc_x, pd_x;

  assign pa_x = REF_W'($signed(pa));
  assign pb_x = REF_W'($signed(pb));
  assign pc_x = REF_W'($signed(pc));
  assign pd_x = REF_W'($signed(pd));

  always_comb begin
    lx_d   = lx_q;
    ly_d   = ly_q;
    cx_d   = cx_q;
    cy_d   = cy_q;
    pend_d = pend_q | ref_wr;
    if (newframe) begin
      lx_d   = bgx;
      ly_d   = bgy;
      cx_d   = bgx;
      cy_d   = bgy;
      pend_d = 1'b0;
    end else if (steprow) begin
      if (pend_q) begin
        lx_d = bgx;
        ly_d = bgy;
      end else begin
        lx_d = lx_q + pb_x;
        ly_d = ly_q + pd_x;
      end
      cx_d   = lx_d;
      cy_d   = ly_d;
      // a write landing on this row edge waits for the next one
      pend_d = ref_wr;
    end else if (step) begin
      cx_d = cx_q + pa_x;
      cy_d = cy_q + pc_x;
    end
  end

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      lx_q   <= '0;
      ly_q   <= '0;
      cx_q   <= '0;
      cy_q   <= '0;
      pend_q <= 1'b0;
    end else begin
      lx_q   <= lx_d;
      ly_q   <= ly_d;
      cx_q   <= cx_d;
      cy_q   <= cy_d;
      pend_q <= pend_d;
    end
  end

  assign cur_x = cx_q;
  assign cur_y = cy_q;

endmodule

// File: rtl/bg_affine_multi.sv
// N-channel affine BG coordinate generator with muxed registered output.
// In: packed refs/params, map size, wrap, sel/step/steprow/newframe.
module bg_affine_multi
  import bg_affine_pkg::*;
#(
  parameter int NUM_BG    = 2,
  parameter int REF_W     = DEF_REF_W,
  parameter int FRAC_BITS = DEF_FRAC,
  parameter int PARAM_W   = DEF_PARAM_W,
  parameter int COORD_W   = DEF_COORD_W,
  parameter int SEL_W     = (NUM_BG > 1) ? $clog2(NUM_BG) : 1
) (
  input  logic                      clock,
  input  logic                      rst_b,
  input  logic [NUM_BG*REF_W-1:0]   bgx,
  input  logic [NUM_BG*REF_W-1:0]   bgy,
  input  logic [NUM_BG*PARAM_W-1:0] pa,
  input  logic [NUM_BG*PARAM_W-1:0] pb,
  input  logic [NUM_BG*PARAM_W-1:0] pc,
  input  logic [NUM_BG*PARAM_W-1:0] pd,
  input  logic [NUM_BG*2-1:0]       map_size,
  input  logic [NUM_BG-1:0]         wrap,
  input  logic [NUM_BG-1:0]         ref_wr,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      step,
  input  logic                      steprow,
  input  logic                      newframe,
  output logic [COORD_W-1:0]        x,
  output logic [COORD_W-1:0]        y,
  output logic                      overflow,
  output logic                      out_valid
);

  localparam int IW = REF_W - FRAC_BITS;

  logic [REF_W-1:0] cur_x [NUM_BG];
  logic [REF_W-1:0] cur_y [NUM_BG];

  logic sel_ok;
  logic step_acc;

  assign sel_ok   = (32'(sel) < NUM_BG);
  assign step_acc = step & ~steprow & ~newframe & sel_ok;

  for (genvar g = 0; g < NUM_BG; g++) begin : g_chan
    bg_affine_chan #(
      .REF_W  (REF_W),
      .PARAM_W(PARAM_W)
    ) u_chan (
      .clock   (clock),
      .rst_b   (rst_b),
      .bgx     (bgx[g*REF_W +: REF_W]),
      .bgy     (bgy[g*REF_W +: REF_W]),
      .pa      (pa[g*PARAM_W +: PARAM_W]),
      .pb      (pb[g*PARAM_W +: PARAM_W]),
      .pc      (pc[g*PARAM_W +: PARAM_W]),
      .pd      (pd[g*PARAM_W +: PARAM_W]),
      .ref_wr  (ref_wr[g]),
      .newframe(newframe),
      .steprow (steprow),
      .step    (step_acc && (sel == SEL_W'(g))),
      .cur_x   (cur_x[g]),
      .cur_y   (cur_y[g])
    );
  end

  logic [REF_W-1:0]   sx, sy;
  map_size_e          sms;
  logic               swrap;
  logic [IW-1:0]      ix, iy, msk;
  logic [COORD_W-1:0] x_d, y_d, x_q, y_q;
  logic               ov_d, ov_q, vld_q;

  always_comb begin
    sx    = '0;
    sy    = '0;
    sms   = MAP_128;
    swrap = 1'b0;
    for (int i = 0; i < NUM_BG; i++) begin
      if (sel == SEL_W'(i)) begin
        sx    = cur_x[i];
        sy    = cur_y[i];
        sms   = map_size_e'(map_size[i*2 +: 2]);
        swrap = wrap[i];
      end
    end
  end

  assign ix  = sx[REF_W-1:FRAC_BITS];
  assign iy  = sy[REF_W-1:FRAC_BITS];
  assign msk = IW'(map_px(sms) - 32'd1);

  always_comb begin
    x_d  = '0;
    y_d  = '0;
    ov_d = 1'b1;
    if (sel_ok) begin
      if (swrap) begin
        x_d  = COORD_W'(ix & msk);
        y_d  = COORD_W'(iy & msk);
        ov_d = 1'b0;
      end else begin
        x_d  = COORD_W'(ix);
        y_d  = COORD_W'(iy);
        // any bit outside the mask means negative or >= map size
        ov_d = (|(ix & ~msk)) | (|(iy & ~msk));
      end
    end
  end

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      x_q   <= '0;
      y_q   <= '0;
      ov_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      ov_q  <= ov_d;
      vld_q <= step_acc;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign overflow  = ov_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_bg_affine_multi.sv
// Self-checking bench for bg_affine_multi.
// Directed cases plus random traffic against a behavioural model.
module tb_bg_affine_multi;

  localparam int NB = 3;
  localparam int RW = 28;
  localparam int FB = 8;
  localparam int PW = 16;
  localparam int CW = 10;
  localparam int SW = 2;

  logic              clock = 1'b0;
  logic              rst_b;
  logic [NB*RW-1:0]  bgx, bgy;
  logic [NB*PW-1:0]  pa, pb, pc, pd;
  logic [NB*2-1:0]   map_size;
  logic [NB-1:0]     wrap, ref_wr;
  logic [SW-1:0]     sel;
  logic              step, steprow, newframe;
  logic [CW-1:0]     x, y;
  logic              overflow, out_valid;

  bg_affine_multi #(
    .NUM_BG(NB), .REF_W(RW), .FRAC_BITS(FB),
    .PARAM_W(PW), .COORD_W(CW), .SEL_W(SW)
  ) dut (
    .clock    (clock),
    .rst_b    (rst_b),
    .bgx      (bgx),
    .bgy      (bgy),
    .pa       (pa),
    .pb       (pb),
    .pc       (pc),
    .pd       (pd),
    .map_size (map_size),
    .wrap     (wrap),
    .ref_wr   (ref_wr),
    .sel      (sel),
    .step     (step),
    .steprow  (steprow),
    .newframe (newframe),
    .x        (x),
    .y        (y),
    .overflow (overflow),
    .out_valid(out_valid)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // model state: plain modular accumulators per channel
  logic [RW-1:0] m_lx [NB];
  logic [RW-1:0] m_ly [NB];
  logic [RW-1:0] m_cx [NB];
  logic [RW-1:0] m_cy [NB];
  bit            m_pend [NB];
  int            ex, ey;
  bit            eov, ev;

  function automatic int ipart(input logic [RW-1:0] v);
    logic signed [RW-1:0] s;
    s = v;
    return int'(s) >>> FB;
  endfunction

  function automatic logic [RW-1:0] prm(input logic [PW-1:0] p);
    logic signed [PW-1:0] s;
    s = p;
    return RW'(int'(s));
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NB; c++) begin
      m_lx[c] = '0; m_ly[c] = '0;
      m_cx[c] = '0; m_cy[c] = '0;
      m_pend[c] = 0;
    end
  endtask

  task automatic model_step();
    int c, ix, iy, m;
    c = int'(sel);
    if (c >= NB) begin
      ex = 0; ey = 0; eov = 1;
    end else begin
      ix = ipart(m_cx[c]);
      iy = ipart(m_cy[c]);
      m  = 128 << map_size[c*2 +: 2];
      if (wrap[c]) begin
        ex = ix & (m - 1);
        ey = iy & (m - 1);
        eov = 0;
      end else begin
        ex = ix & ((1 << CW) - 1);
        ey = iy & ((1 << CW) - 1);
        eov = (ix < 0) || (ix >= m) || (iy < 0) || (iy >= m);
      end
    end
    ev = step && !steprow && !newframe && (c < NB);
    for (int k = 0; k < NB; k++) begin
      if (newframe) begin
        m_lx[k] = bgx[k*RW +: RW];
        m_ly[k] = bgy[k*RW +: RW];
        m_cx[k] = m_lx[k];
        m_cy[k] = m_ly[k];
        m_pend[k] = 0;
      end else if (steprow) begin
        if (m_pend[k]) begin
          m_lx[k] = bgx[k*RW +: RW];
          m_ly[k] = bgy[k*RW +: RW];
        end else begin
          m_lx[k] = m_lx[k] + prm(pb[k*PW +: PW]);
          m_ly[k] = m_ly[k] + prm(pd[k*PW +: PW]);
        end
        m_cx[k] = m_lx[k];
        m_cy[k] = m_ly[k];
        m_pend[k] = ref_wr[k];
      end else begin
        if (ev && k == c) begin
          m_cx[k] = m_cx[k] + prm(pa[k*PW +: PW]);
          m_cy[k] = m_cy[k] + prm(pc[k*PW +: PW]);
        end
        if (ref_wr[k]) m_pend[k] = 1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    check("x", 32'(x), 32'(ex));
    check("y", 32'(y), 32'(ey));
    check("ovf", 32'(overflow), 32'(eov));
    check("vld", 32'(out_valid), 32'(ev));
    step = 0; steprow = 0; newframe = 0; ref_wr = '0;
  endtask

  task automatic set_ch(input int c, input int bx, input int by,
                        input int a, input int b,
                        input int cc, input int d,
                        input int ms, input bit wr);
    bgx[c*RW +: RW] = RW'(bx);
    bgy[c*RW +: RW] = RW'(by);
    pa[c*PW +: PW] = PW'(a);
    pb[c*PW +: PW] = PW'(b);
    pc[c*PW +: PW] = PW'(cc);
    pd[c*PW +: PW] = PW'(d);
    map_size[c*2 +: 2] = 2'(ms);
    wrap[c] = wr;
  endtask

  initial begin
    rst_b = 0;
    bgx = '0; bgy = '0;
    pa = '0; pb = '0; pc = '0; pd = '0;
    map_size = '0; wrap = '0; ref_wr = '0;
    sel = '0; step = 0; steprow = 0; newframe = 0;
    model_reset();
    #22;
    check("rst_x", 32'(x), 0);
    check("rst_y", 32'(y), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_vld", 32'(out_valid), 0);
    rst_b = 1;

    // identity walk
    set_ch(0, 0, 0, 'h100, 0, 0, 0, 3, 0);
    newframe = 1; tick();
    sel = 0;
    step = 1; tick();
    step = 1; tick();
    step = 1; tick();
    check("ident_x", 32'(x), 2);
    check("ident_vld", 32'(out_valid), 1);

    // line advance, two channels
    set_ch(0, 0, 0, 'h100, 0, 0, 'h100, 3, 0);
    set_ch(1, 'h500, 0, 'h100, 0, 0, 'h100, 3, 0);
    newframe = 1; tick();
    steprow = 1; tick();
    steprow = 1; tick();
    sel = 0; step = 1; tick();
    check("line_x", 32'(x), 0);
    check("line_y", 32'(y), 2);
    sel = 1; step = 1; tick();
    check("ch1_x", 32'(x), 5);
    sel = 0; tick();
    check("ch0_keep", 32'(x), 1);

    // bounds
    set_ch(0, -(5 << 8), 0, 0, 0, 0, 0, 0, 0);
    newframe = 1; tick();
    tick();
    check("neg_ovf", 32'(overflow), 1);
    wrap[0] = 1; tick();
    check("wrap_x", 32'(x), 123);
    check("wrap_ovf", 32'(overflow), 0);
    set_ch(0, 128 << 8, 0, 0, 0, 0, 0, 0, 0);
    newframe = 1; tick();
    tick();
    check("hi_ovf", 32'(overflow), 1);

    // mid-frame reload
    set_ch(0, 0, 0, 'h100, 0, 0, 'h100, 3, 0);
    newframe = 1; tick();
    repeat (4) begin steprow = 1; tick(); end
    bgx[0 +: RW] = RW'('h2000); ref_wr[0] = 1; tick();
    tick();
    check("pend_hold", 32'(x), 0);
    steprow = 1; tick();
    step = 1; tick();
    check("reload_x", 32'(x), 32);

    // asynchronous reset between edges
    rst_b = 0;
    #2;
    check("amid_x", 32'(x), 0);
    check("amid_y", 32'(y), 0);
    check("amid_ovf", 32'(overflow), 0);
    check("amid_vld", 32'(out_valid), 0);
    model_reset();
    @(negedge clock);
    rst_b = 1;
    sel = 0; step = 1; tick();
    step = 1; tick();
    check("post_rst_x", 32'(x), 1);

    // simultaneous controls
    set_ch(0, 'h300, 'h700, 'h100, 0, 0, 'h100, 3, 0);
    newframe = 1; steprow = 1; step = 1; tick();
    check("sim_vld", 32'(out_valid), 0);
    tick();
    check("sim_x", 32'(x), 3);
    check("sim_y", 32'(y), 7);
    bgy[0 +: RW] = RW'('h900); ref_wr[0] = 1; newframe = 1; tick();
    steprow = 1; tick();
    tick();
    check("nf_ref_y", 32'(y), 10);

    // random traffic
    for (int c = 0; c < NB; c++)
      set_ch(c, 0, 0, 'h100, 0, 0, 'h100, 3, 0);
    newframe = 1; tick();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 29) == 0) begin
        for (int c = 0; c < NB; c++)
          set_ch(c, int'($urandom) >>> 4, int'($urandom) >>> 4,
                 int'($urandom_range(0, 'h3ff)) - 'h200,
                 int'($urandom_range(0, 'h3ff)) - 'h200,
                 int'($urandom_range(0, 'h3ff)) - 'h200,
                 int'($urandom_range(0, 'h3ff)) - 'h200,
                 int'($urandom_range(0, 3)), 1'($urandom));
      end
      for (int c = 0; c < NB; c++) begin
        if ($urandom_range(0, 9) == 0) begin
          ref_wr[c] = 1;
          bgx[c*RW +: RW] = RW'(int'($urandom) >>> 6);
          bgy[c*RW +: RW] = RW'(int'($urandom) >>> 6);
        end
      end
      sel      = SW'($urandom_range(0, 3));
      step     = ($urandom_range(0, 1) == 1);
      steprow  = ($urandom_range(0, 7) == 0);
      newframe = ($urandom_range(0, 24) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bg_affine_multi.md
Name: bg_affine_multi

Overview:
- Parametrised N-channel affine (rotation/scaling) background coordinate generator for the BG processing circuit.
- Each channel keeps a line-start and a current-pixel accumulator, advanced by the PA/PC/PB/PD parameters.
- Adds map-size-aware wraparound and overflow detection, mid-frame reference-point reload, and a registered, muxed coordinate output with a valid strobe.
- Sits between the BG register file and the tile/bitmap fetch unit.

Parameters:
- NUM_BG, 2, number of affine channels (channel 0 = BG2, channel 1 = BG3, ...).
- REF_W, 28, reference point/accumulator width; signed fixed point.
- FRAC_BITS, 8, fractional bits in REF_W and in PARAM_W.
- PARAM_W, 16, signed PA/PB/PC/PD width.
- COORD_W, 10, output integer coordinate width.
- SEL_W, $clog2(NUM_BG) (min 1), channel select width.

Ports:
- clock  in  1  system clock.
- rst_b  in  1  asynchronous active-low reset.
- bgx  in  NUM_BG*REF_W  packed reference X per channel.
- bgy  in  NUM_BG*REF_W  packed reference Y per channel.
- pa, pb, pc, pd  in  NUM_BG*PARAM_W each  packed affine parameters.
- map_size  in  NUM_BG*2  per channel: 0=128, 1=256, 2=512, 3=1024 px.
- wrap  in  NUM_BG  per-channel wraparound enable.
- ref_wr  in  NUM_BG  pulse: bgx/bgy for that channel rewritten mid-frame.
- sel  in  SEL_W  channel being fetched.
- step  in  1  advance selected channel one pixel.
- steprow  in  1  advance all channels one line.
- newframe  in  1  reload all channels from bgx/bgy.
- x, y  out  COORD_W each  integer coordinate of the selected channel.
- overflow  out  1  selected coordinate outside the map with wrap off.
- out_valid  out  1  x/y/overflow correspond to a step.

Behaviour:
- Per channel: line_x, line_y, cur_x, cur_y, all REF_W signed; pend_ref flag.
- Reset: all accumulators 0, pend_ref 0, x=0, y=0, overflow=0, out_valid=0. Reset mid-frame discards all state.
- newframe: line and cur registers load bgx/bgy for every channel; pend_ref cleared. Highest priority.
- steprow (no newframe), per channel:
  - If pend_ref: line and cur load bgx/bgy; clear pend_ref.
  - Otherwise: line_x += sext(pb), line_y += sext(pd); cur loads the new line values.
- step (no newframe, no steprow), channel sel only: cur_x += sext(pa), cur_y += sext(pc).
- step in the same cycle as steprow or newframe is dropped.
- Arithmetic: parameters are sign-extended to REF_W. Sums wrap modulo 2^REF_W with no saturation.
- ref_wr: sets pend_ref for that channel, taking effect at the next steprow. If ref_wr coincides with newframe, newframe loads the new value and pend_ref stays clear.
- Output stage, registered with 1-cycle latency. Each cycle, sample the pre-update cur of channel sel:
  - ix = cur_x[REF_W-1:FRAC_BITS] (signed); same for iy.
  - M = 128 << map_size.
  - Wrap on: x = ix & (M-1), y likewise; overflow = 0.
  - Wrap off: overflow = (ix<0 | ix>=M | iy<0 | iy>=M); x/y = low COORD_W bits of ix/iy.
- out_valid (registered) = step accepted in the previous cycle. In a step cycle t, x/y at t+1 are the pixel position at t.
- sel >= NUM_BG: step ignored, x=y=0, overflow=1, out_valid=0.

Decomposition:
- Package bg_affine_pkg: map_size encoding enum, MAP_PX lookup (128..1024), default widths, sext helper function.
- Sub-module bg_affine_chan: one channel's accumulators, pend_ref and priority logic, instantiated NUM_BG times via generate.
- Top level: output mux, wrap/overflow logic and output registers.

Test Plan:
- Identity: pa=0x100, pc=0, bgx=bgy=0, newframe, then 3 steps on sel=0 -> x=0,1,2, y=0, out_valid high each following cycle.
- Line advance: pd=0x100, pb=0, after 2 steprows then 1 step -> x=0, y=2. Channel 1 with distinct bgx=0x500 steps concurrently-selected -> x=5, channel 0 unaffected.
- Bounds: bgx=-5<<8, map_size=0:
  - wrap=0 -> overflow=1.
  - wrap=1 -> x=123, overflow=0.
  - bgx=128<<8, wrap=0 -> overflow=1.
- Mid-frame reload: after 4 steprows, bgx=0x2000 with ref_wr pulse, then steprow -> next step outputs x=32. Without the steprow, x is unchanged.
- Simultaneous: newframe+steprow+step in one cycle -> cur=bgx/bgy exactly, out_valid=0 next cycle. ref_wr+newframe -> new value loaded, later steprow increments by pd (no reload).
- Reset mid-frame (rst_b low asynchronously between clocks) -> x, y, overflow, out_valid=0 immediately. After release, step without newframe -> x=1 from origin (pa=0x100).
